// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master: turns one user command into one
// AXI-Lite read or write and reports the completion on a one-cycle pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a user command
// WR_AW_W | write address and write data channels in flight
// WR_B    | both write channels done, waiting for the write response
// RD_AR   | read address channel in flight
// RD_R    | waiting for read data
// DONE    | rsp_valid pulse, returns to IDLE
module axi_lite_master (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [5:0]  axi_awaddr,
  output logic [2:0]  axi_awprot,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [5:0]  axi_araddr,
  output logic [2:0]  axi_arprot,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  localparam logic [5:0] ADDR_ALIGN_MASK = 6'b111100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        awvalid_d;
  logic        wvalid_d;
  logic [5:0]  awaddr_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [5:0]  araddr_d;
  logic        rsp_write_d;
  logic [31:0] rsp_rdata_d;
  logic [1:0]  rsp_resp_d;

  logic        cmd_ready_d;
  logic        rsp_valid_d;
  logic        bready_d;
  logic        arvalid_d;
  logic        rready_d;

  // Protection attributes are fixed: unprivileged, secure, data access.
  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;

  // Next state and next values of the datapath registers.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = axi_awvalid;
    wvalid_d    = axi_wvalid;
    awaddr_d    = axi_awaddr;
    wdata_d     = axi_wdata;
    wstrb_d     = axi_wstrb;
    araddr_d    = axi_araddr;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            state_d   = WR_AW_W;
            awaddr_d  = cmd_addr & ADDR_ALIGN_MASK;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d  = RD_AR;
            araddr_d = cmd_addr & ADDR_ALIGN_MASK;
          end
        end
      end

      WR_AW_W: begin
        // Each channel retires on its own handshake; order does not matter.
        if (axi_awvalid && axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (axi_wvalid && axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_B;
        end
      end

      WR_B: begin
        if (axi_bvalid && axi_bready) begin
          state_d     = DONE;
          rsp_write_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_resp_d  = axi_bresp;
        end
      end

      RD_AR: begin
        if (axi_arvalid && axi_arready) begin
          state_d = RD_R;
        end
      end

      RD_R: begin
        if (axi_rvalid && axi_rready) begin
          state_d     = DONE;
          rsp_write_d = 1'b0;
          rsp_rdata_d = axi_rdata;
          rsp_resp_d  = axi_rresp;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control outputs are pure functions of the state being entered, so
  // registering them makes them line up exactly with that state.
  assign cmd_ready_d = (state_d == IDLE);
  assign rsp_valid_d = (state_d == DONE);
  assign bready_d    = (state_d == WR_B);
  assign arvalid_d   = (state_d == RD_AR);
  assign rready_d    = (state_d == RD_R);

  // State register and registered outputs; reset aborts any transfer.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q     <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_resp    <= 2'b00;
      axi_awaddr  <= 6'h0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= 32'h0;
      axi_wstrb   <= 4'h0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_araddr  <= 6'h0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_write   <= rsp_write_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_resp    <= rsp_resp_d;
      axi_awaddr  <= awaddr_d;
      axi_awvalid <= awvalid_d;
      axi_wdata   <= wdata_d;
      axi_wstrb   <= wstrb_d;
      axi_wvalid  <= wvalid_d;
      axi_bready  <= bready_d;
      axi_araddr  <= araddr_d;
      axi_arvalid <= arvalid_d;
      axi_rready  <= rready_d;
    end
  end

endmodule
